// File: rtl/ssemi_decimator_config_sequencer.sv
// Brings the CIC/FIR/halfband decimator into operation: drains the datapath, streams
// coefficients from the store into the config port, programs the factor, flushes, runs.
module ssemi_decimator_config_sequencer #(
  parameter int         FIR_TAPS       = 64,
  parameter int         HALFBAND_TAPS  = 33,
  parameter logic [7:0] FIR_BASE_ADDR  = 8'h00,
  parameter logic [7:0] HB_BASE_ADDR   = 8'h80,
  parameter logic [7:0] DECIM_ADDR     = 8'hF0,
  parameter int         FLUSH_CYCLES   = 16,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [9:0]  i_decimation_factor,
  output logic        o_coef_rd_en,
  output logic [7:0]  o_coef_rd_addr,
  input  logic [31:0] i_coef_rd_data,
  output logic        o_config_valid,
  output logic [7:0]  o_config_addr,
  output logic [31:0] o_config_data,
  input  logic        i_config_ready,
  output logic        o_dp_enable,
  input  logic        i_dp_busy,
  output logic        o_running,
  output logic        o_done,
  output logic        o_error,
  output logic [1:0]  o_error_code,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_FETCH  = 3'd2,
    S_RDWAIT = 3'd3,
    S_WRITE  = 3'd4,
    S_DECIM  = 3'd5,
    S_SETTLE = 3'd6,
    S_RUN    = 3'd7
  } state_t;

  localparam int TOTAL_TAPS = FIR_TAPS + HALFBAND_TAPS;
  localparam int CNT_MAX    = (TIMEOUT_CYCLES > FLUSH_CYCLES) ? TIMEOUT_CYCLES : FLUSH_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [1:0] ERR_FACTOR = 2'd1;
  localparam logic [1:0] ERR_DRAIN  = 2'd2;
  localparam logic [1:0] ERR_CONFIG = 2'd3;

  state_t           state_q;
  logic [7:0]       idx_q;
  logic [9:0]       factor_q;
  logic [CNT_W-1:0] cnt_q;
  logic             low_seen_q;

  logic             start_ok_d;
  logic             factor_ok_d;
  logic             tmo_hit_d;
  logic             flush_done_d;
  logic             last_coef_d;
  logic [7:0]       cfg_addr_d;

  always_comb begin
    factor_ok_d = 1'b0;
    case (i_decimation_factor)
      10'd32, 10'd64, 10'd128, 10'd256, 10'd512: factor_ok_d = 1'b1;
      default:                                   factor_ok_d = 1'b0;
    endcase
  end

  assign start_ok_d   = i_start && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign tmo_hit_d    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign flush_done_d = (cnt_q == CNT_W'(FLUSH_CYCLES - 1));
  assign last_coef_d  = (idx_q == 8'(TOTAL_TAPS - 1));
  // Coefficient index maps into two disjoint config windows.
  assign cfg_addr_d   = (idx_q < 8'(FIR_TAPS)) ? (FIR_BASE_ADDR + idx_q)
                                               : (HB_BASE_ADDR + (idx_q - 8'(FIR_TAPS)));
  assign o_state      = state_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= S_IDLE;
      idx_q          <= 8'd0;
      factor_q       <= 10'd0;
      cnt_q          <= '0;
      low_seen_q     <= 1'b0;
      o_coef_rd_en   <= 1'b0;
      o_coef_rd_addr <= 8'd0;
      o_config_valid <= 1'b0;
      o_config_addr  <= 8'd0;
      o_config_data  <= 32'd0;
      o_dp_enable    <= 1'b0;
      o_running      <= 1'b0;
      o_done         <= 1'b0;
      o_error        <= 1'b0;
      o_error_code   <= 2'd0;
    end else begin
      o_done <= 1'b0;
      if (start_ok_d) begin
        o_error      <= 1'b0;
        o_error_code <= 2'd0;
        o_running    <= 1'b0;
        o_dp_enable  <= 1'b0;
        idx_q        <= 8'd0;
        cnt_q        <= '0;
        low_seen_q   <= 1'b0;
        if (factor_ok_d) begin
          factor_q <= i_decimation_factor;
          state_q  <= S_DRAIN;
        end else begin
          o_error      <= 1'b1;
          o_error_code <= ERR_FACTOR;
          state_q      <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_DRAIN: begin
            if (!i_dp_busy && low_seen_q) begin
              o_coef_rd_en   <= 1'b1;
              o_coef_rd_addr <= idx_q;
              state_q        <= S_FETCH;
            end else if (tmo_hit_d) begin
              o_error      <= 1'b1;
              o_error_code <= ERR_DRAIN;
              state_q      <= S_IDLE;
            end else begin
              low_seen_q <= !i_dp_busy;
              cnt_q      <= cnt_q + CNT_W'(1);
            end
          end
          S_FETCH: begin
            o_coef_rd_en <= 1'b0;
            state_q      <= S_RDWAIT;
          end
          S_RDWAIT: begin
            o_config_data  <= i_coef_rd_data;
            o_config_addr  <= cfg_addr_d;
            o_config_valid <= 1'b1;
            cnt_q          <= '0;
            state_q        <= S_WRITE;
          end
          S_WRITE: begin
            if (i_config_ready) begin
              idx_q <= idx_q + 8'd1;
              cnt_q <= '0;
              if (last_coef_d) begin
                // Valid stays high: the factor write follows back-to-back.
                o_config_addr <= DECIM_ADDR;
                o_config_data <= {22'b0, factor_q};
                state_q       <= S_DECIM;
              end else begin
                o_config_valid <= 1'b0;
                o_coef_rd_en   <= 1'b1;
                o_coef_rd_addr <= idx_q + 8'd1;
                state_q        <= S_FETCH;
              end
            end else if (tmo_hit_d) begin
              o_config_valid <= 1'b0;
              o_error        <= 1'b1;
              o_error_code   <= ERR_CONFIG;
              state_q        <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_DECIM: begin
            if (i_config_ready) begin
              o_config_valid <= 1'b0;
              o_dp_enable    <= 1'b1;
              cnt_q          <= '0;
              state_q        <= S_SETTLE;
            end else if (tmo_hit_d) begin
              o_config_valid <= 1'b0;
              o_error        <= 1'b1;
              o_error_code   <= ERR_CONFIG;
              state_q        <= S_IDLE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          S_SETTLE: begin
            if (flush_done_d) begin
              o_running <= 1'b1;
              o_done    <= 1'b1;
              state_q   <= S_RUN;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ssemi_decimator_config_sequencer.sv
// Scoreboard bench: stimulus pushes expected config writes and o_done latencies,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_ssemi_decimator_config_sequencer;

  localparam int FIR_TAPS = 4;
  localparam int HB_TAPS  = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  factor = 10'd0;
  logic        coef_en;
  logic [7:0]  coef_addr;
  logic [31:0] coef_data = 32'd0;
  logic        cfg_valid;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic        cfg_ready = 1'b1;
  logic        dp_en;
  logic        busy = 1'b0;
  logic        running;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [2:0]  state;

  ssemi_decimator_config_sequencer #(
    .FIR_TAPS(FIR_TAPS), .HALFBAND_TAPS(HB_TAPS), .FLUSH_CYCLES(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_decimation_factor(factor),
    .o_coef_rd_en(coef_en), .o_coef_rd_addr(coef_addr), .i_coef_rd_data(coef_data),
    .o_config_valid(cfg_valid), .o_config_addr(cfg_addr), .o_config_data(cfg_data),
    .i_config_ready(cfg_ready), .o_dp_enable(dp_en), .i_dp_busy(busy),
    .o_running(running), .o_done(done), .o_error(err), .o_error_code(err_code),
    .o_state(state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Coefficient store: entry i holds i*0x11, one-cycle read latency.
  always @(posedge clk) coef_data <= coef_en ? ({24'h0, coef_addr} * 32'h11) : 32'hDEAD_BEEF;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  start_cyc = 0;
  int  tests = 0;
  int  fails = 0;
  int  ready_mode = 0;  // 0: always ready, 1: 3 stall cycles per WRITE, 2: never ready

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready driver, updated just after each rising edge.
  initial begin
    int wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: cfg_ready = 1'b1;
        2: cfg_ready = 1'b0;
        default: begin
          if (state == 3'd4) begin
            cfg_ready = (wcnt >= 3);
            wcnt++;
          end else begin
            wcnt = 0;
            cfg_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: every cycle valid is high, address/data must equal the pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && cfg_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_write: got %02h <= %08h, expected no write", cfg_addr, cfg_data);
        end else begin
          check("cfg_addr", {24'h0, cfg_addr}, {24'h0, exp_q[0].addr});
          check("cfg_data", cfg_data, exp_q[0].data);
          if (cfg_ready) begin
            $display("[TB] write %02h <= %08h", cfg_addr, cfg_data);
            void'(exp_q.pop_front());
          end
        end
      end
      if (!rst && done) begin
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_done: got done at cycle %0d, expected none", cyc - start_cyc + 1);
        end else begin
          $display("[TB] done at cycle %0d", cyc - start_cyc + 1);
          check("done_cycle", 32'(cyc - start_cyc + 1), 32'(done_q.pop_front()));
          check("running_with_done", {31'h0, running}, 32'd1);
        end
      end
    end
  end

  task automatic expect_load(input logic [9:0] f);
    wr_t w;
    for (int i = 0; i < FIR_TAPS + HB_TAPS; i++) begin
      w.addr = (i < FIR_TAPS) ? 8'(i) : 8'(8'h80 + i - FIR_TAPS);
      w.data = 32'(i) * 32'h11;
      exp_q.push_back(w);
    end
    w.addr = 8'hF0;
    w.data = {22'b0, f};
    exp_q.push_back(w);
  endtask

  // Start high during cycle 0; returns just after the sampling edge (cycle 1).
  task automatic do_start(input logic [9:0] f);
    @(posedge clk);
    #1;
    start  = 1'b1;
    factor = f;
    @(posedge clk);
    #1;
    start     = 1'b0;
    start_cyc = cyc;
    $display("[TB] start factor %0d", f);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 3000);
    check(name, {31'h0, done}, 32'd1);
    check("writes_drained", 32'(exp_q.size()), 32'd0);
    check("run_state", {29'h0, state}, 32'd7);
    check("run_dp_enable", {31'h0, dp_en}, 32'd1);
  endtask

  task automatic wait_error(output int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!err && n < 3000);
    check("error_seen", {31'h0, err}, 32'd1);
    lat = cyc - start_cyc + 1;
  endtask

  initial begin
    int lat;
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", {29'h0, state}, 32'd0);
    check("rst_outputs", {24'h0, cfg_valid, dp_en, running, done, err, err_code, coef_en}, 32'd0);
    rst = 1'b0;

    // Nominal load: factor 64 -> F0 <= 0x40, done at cycle 47
    expect_load(10'd64);
    done_q.push_back(47);
    do_start(10'd64);
    wait_done("nominal_done");

    // Backpressure on every WRITE, started from RUN: done at cycle 74
    ready_mode = 1;
    expect_load(10'd128);
    done_q.push_back(74);
    do_start(10'd128);
    check("restart_drops_enable", {31'h0, dp_en}, 32'd0);
    wait_done("backpressure_done");
    ready_mode = 0;

    // Bad factors: 48, then 1024 which wraps to 0 on the 10-bit input
    do_start(10'd48);
    check("bad48_code", {30'h0, err_code}, 32'd1);
    check("bad48_dp_enable", {31'h0, dp_en}, 32'd0);
    check("bad48_running", {31'h0, running}, 32'd0);
    check("bad48_state", {29'h0, state}, 32'd0);
    do_start(10'd0);
    check("bad1024_code", {30'h0, err_code}, 32'd1);
    expect_load(10'd256);
    done_q.push_back(47);
    do_start(10'd256);
    check("valid_start_clears_err", {29'h0, err, err_code}, 32'd0);
    check("valid_start_state", {29'h0, state}, 32'd1);
    wait_done("after_bad_done");

    // Drain timeout: busy stuck high, error after 1024 DRAIN cycles
    busy = 1'b1;
    do_start(10'd32);
    wait_error(lat);
    check("drain_tmo_cycle", 32'(lat), 32'd1025);
    check("drain_tmo_code", {30'h0, err_code}, 32'd2);
    check("drain_tmo_state", {29'h0, state}, 32'd0);
    check("drain_tmo_dp_enable", {31'h0, dp_en}, 32'd0);
    busy = 1'b0;
    expect_load(10'd512);
    done_q.push_back(47);
    do_start(10'd512);
    wait_done("after_drain_done");

    // Restart from RUN with busy high for the first 5 DRAIN cycles: done at 52
    busy = 1'b1;
    expect_load(10'd64);
    done_q.push_back(52);
    do_start(10'd64);
    repeat (5) @(posedge clk);
    #1;
    busy = 1'b0;
    wait_done("busy_pulse_done");

    // Config timeout: ready never asserts
    ready_mode = 2;
    expect_load(10'd32);
    do_start(10'd32);
    wait_error(lat);
    check("cfg_tmo_cycle", 32'(lat), 32'd1029);
    check("cfg_tmo_code", {30'h0, err_code}, 32'd3);
    check("cfg_tmo_valid", {31'h0, cfg_valid}, 32'd0);
    check("cfg_tmo_state", {29'h0, state}, 32'd0);
    exp_q.delete();

    // Asynchronous reset while a write is stalled
    expect_load(10'd32);
    do_start(10'd32);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (state != 3'd4 && n < 100);
    check("reached_write", {29'h0, state}, 32'd4);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_state", {29'h0, state}, 32'd0);
    check("midrst_ctrl", {24'h0, cfg_valid, dp_en, running, done, err, err_code, coef_en}, 32'd0);
    check("midrst_addr", {16'h0, cfg_addr, coef_addr}, 32'd0);
    check("midrst_data", cfg_data, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;

    // Recovery after reset
    expect_load(10'd64);
    done_q.push_back(47);
    do_start(10'd64);
    wait_done("post_reset_done");
    check("done_queue_empty", 32'(done_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
